// File: rtl/serial_alu_sequencer_pkg.sv
// Shared types for the bit-serial ALU sequencer: ALU op codes, sequencer
// states and the control-op decoder.
package serial_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_SLT  = 2'd2,
    ALU_SLTU = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    unsupported;
  } op_decode_t;

  // Codes above SLTU fall back to ADD and are flagged to the consumer.
  function automatic op_decode_t decode_op(input logic [3:0] code);
    op_decode_t d;
    d.unsupported = (code > 4'd3);
    d.op          = d.unsupported ? ALU_ADD : alu_op_e'(code[1:0]);
    return d;
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Operand/control request channel and result/flag response channel of the
// bit-serial ALU sequencer.
interface serial_alu_sequencer_if #(
  parameter int XLEN = 32
);
  // Both channels use valid/ready: a beat transfers on a rising edge where
  // valid && ready; once valid is raised the sender holds it and its payload
  // stable until that edge, and ready never waits on valid.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_ctrlALUSrc;
  logic [3:0]      in_ctrlOP;
  logic            in_ctrlBranch;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_lt;
  logic            out_ovf;
  logic            out_unsupported;

  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_ctrlALUSrc, in_ctrlOP, in_ctrlBranch,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_zero, out_lt, out_ovf, out_unsupported
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_ctrlALUSrc, in_ctrlOP, in_ctrlBranch,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_zero, out_lt, out_ovf, out_unsupported
  );
endinterface

// File: rtl/full_adder.sv
// Single-bit combinational full adder driven by the serial ALU sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU front end: streams operand bits LSB first through an external
// full adder, carries between cycles, and returns the assembled sum with flags.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  serial_alu_sequencer_if.slave   bus,
  output logic                    fa_a,
  output logic                    fa_b,
  output logic                    fa_cin,
  input  logic                    fa_sum,
  input  logic                    fa_cout,
  output seq_state_e              dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(XLEN - 1);

  seq_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] a_sh;
  logic [XLEN-1:0] b_sh;
  logic [XLEN-1:0] res_sh;
  logic            carry_reg;
  alu_op_e         op_reg;
  logic            unsup_reg;

  logic            out_valid_r;
  logic [XLEN-1:0] out_result_r;
  logic            out_zero_r;
  logic            out_lt_r;
  logic            out_ovf_r;
  logic            out_unsup_r;

  op_decode_t      dec;
  logic            invert_acc;
  logic [XLEN-1:0] b_sel;
  logic            in_shift;
  logic [XLEN-1:0] sum_next;
  logic            ovf_c;
  logic            lt_sel;
  logic [XLEN-1:0] result_c;

  always_comb begin
    dec        = decode_op(bus.in_ctrlOP);
    invert_acc = (dec.op != ALU_ADD) || bus.in_ctrlBranch;
    b_sel      = bus.in_ctrlALUSrc ? bus.in_imm : bus.in_rs2;
  end

  assign in_shift = (state == ST_SHIFT);

  // B is stored pre-inverted for the SUB path; the +1 comes from the seeded carry.
  assign fa_a   = in_shift & a_sh[0];
  assign fa_b   = in_shift & b_sh[0];
  assign fa_cin = in_shift & carry_reg;

  // Final-bit flag logic: carry_reg is the carry into the MSB, fa_cout the carry out.
  always_comb begin
    sum_next = {fa_sum, res_sh[XLEN-1:1]};
    ovf_c    = carry_reg ^ fa_cout;
    lt_sel   = (op_reg == ALU_SLTU) ? ~fa_cout : (sum_next[XLEN-1] ^ ovf_c);
    result_c = sum_next;
    if ((op_reg == ALU_SLT) || (op_reg == ALU_SLTU)) begin
      result_c = {{(XLEN-1){1'b0}}, lt_sel};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      carry_reg    <= 1'b0;
      op_reg       <= ALU_ADD;
      unsup_reg    <= 1'b0;
      out_valid_r  <= 1'b0;
      out_result_r <= '0;
      out_zero_r   <= 1'b0;
      out_lt_r     <= 1'b0;
      out_ovf_r    <= 1'b0;
      out_unsup_r  <= 1'b0;
    end else if (flush) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      carry_reg   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sh      <= bus.in_rs1;
            b_sh      <= b_sel ^ {XLEN{invert_acc}};
            res_sh    <= '0;
            carry_reg <= invert_acc;
            op_reg    <= dec.op;
            unsup_reg <= dec.unsupported;
            cnt       <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          res_sh    <= sum_next;
          carry_reg <= fa_cout;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            cnt          <= '0;
            out_valid_r  <= 1'b1;
            out_result_r <= result_c;
            out_zero_r   <= (sum_next == '0);
            out_lt_r     <= lt_sel;
            out_ovf_r    <= ovf_c;
            out_unsup_r  <= unsup_reg;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready        = (state == ST_IDLE);
  assign bus.out_valid       = out_valid_r;
  assign bus.out_result      = out_result_r;
  assign bus.out_zero        = out_zero_r;
  assign bus.out_lt          = out_lt_r;
  assign bus.out_ovf         = out_ovf_r;
  assign bus.out_unsupported = out_unsup_r;
  assign dbg_state           = state;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Self-checking bench for serial_alu_sequencer wired to a real full_adder;
// expected results come from a word-level arithmetic model via a queue.
module tb_serial_alu_sequencer;
  import serial_alu_sequencer_pkg::*;

  localparam int XLEN    = 32;
  localparam int EW      = XLEN + 4;
  localparam int TIMEOUT = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  seq_state_e dbg_state;

  serial_alu_sequencer_if #(.XLEN(XLEN)) bus ();

  serial_alu_sequencer #(.XLEN(XLEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout),
    .dbg_state (dbg_state)
  );

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  wire [EW-1:0] act = {bus.out_result, bus.out_zero, bus.out_lt, bus.out_ovf, bus.out_unsupported};

  function automatic logic [EW-1:0] model(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                          input logic [XLEN-1:0] imm, input logic src,
                                          input logic [3:0] op, input logic br);
    logic [XLEN-1:0] a, b, s, res;
    logic sub, unsup, ovf, lt, zero;
    a     = rs1;
    b     = src ? imm : rs2;
    unsup = (op > 4'd3);
    sub   = (!unsup && op != 4'd0) || br;
    if (sub) begin
      s   = a - b;
      ovf = (a[XLEN-1] != b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      lt  = (op == 4'd3) ? (a < b) : ($signed(a) < $signed(b));
    end else begin
      s   = a + b;
      ovf = (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      lt  = s[XLEN-1] ^ ovf;
    end
    zero = (s == '0);
    res  = (!unsup && (op == 4'd2 || op == 4'd3)) ? XLEN'(lt) : s;
    return {res, zero, lt, ovf, unsup};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                          input logic [XLEN-1:0] imm, input logic src,
                          input logic [3:0] op, input logic br);
    int guard = 0;
    @(negedge clock);
    while (!bus.in_ready && guard < TIMEOUT) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL drive_in_ready: in_ready=%0b after %0d cycles, required 1", bus.in_ready, guard);
    end
    bus.in_rs1        = rs1;
    bus.in_rs2        = rs2;
    bus.in_imm        = imm;
    bus.in_ctrlALUSrc = src;
    bus.in_ctrlOP     = op;
    bus.in_ctrlBranch = br;
    bus.in_valid      = 1'b1;
    exp_q.push_back(model(rs1, rs2, imm, src, op, br));
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < TIMEOUT);
  endtask

  task automatic release_result();
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || act !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%0b fields=%h, required 0/0", bus.out_valid, act);
    end
    checks++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
      errors++;
      $display("FAIL reset_fa: fa=%b, required 000", {fa_a, fa_b, fa_cin});
    end
    checks++;
    if (bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%0b state=%0d, required 1/IDLE", bus.in_ready, dbg_state);
    end
  endtask

  task automatic test_add();
    int cyc;
    logic [EW-1:0] e;
    drive_op(32'd5, 32'd7, 32'd0, 1'b0, 4'd0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (!bus.out_valid || (cyc + 1) != XLEN + 1) begin
      errors++;
      $display("FAIL add_latency: valid=%0b after %0d cycles from accept, required %0d", bus.out_valid, cyc + 1, XLEN + 1);
    end
    e = exp_q.pop_front();
    checks++;
    if (act !== e || bus.out_result !== 32'h0000000C) begin
      errors++;
      $display("FAIL add_5_7: got %h, required %h", act, e);
    end
    release_result();
  endtask

  task automatic test_sub_sltu();
    logic [XLEN-1:0] rs1_t[2] = '{32'h0, 32'hFFFFFFFF};
    logic [XLEN-1:0] rs2_t[2] = '{32'h1, 32'h0};
    logic [XLEN-1:0] imm_t[2] = '{32'h0, 32'h1};
    logic            src_t[2] = '{1'b0, 1'b1};
    logic [3:0]      op_t[2]  = '{4'd1, 4'd3};
    logic [XLEN-1:0] res_t[2] = '{32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 2; i++) begin
      int cyc;
      logic [EW-1:0] e;
      drive_op(rs1_t[i], rs2_t[i], imm_t[i], src_t[i], op_t[i], 1'b0);
      wait_valid(cyc);
      e = exp_q.pop_front();
      checks++;
      if (!bus.out_valid || act !== e || bus.out_result !== res_t[i]) begin
        errors++;
        $display("FAIL sub_sltu[%0d]: valid=%0b got %h, required %h", i, bus.out_valid, act, e);
      end
      release_result();
    end
  endtask

  task automatic test_ovf_slt();
    logic [XLEN-1:0] rs1_t[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] rs2_t[2] = '{32'h1, 32'h1};
    logic [3:0]      op_t[2]  = '{4'd0, 4'd2};
    logic [XLEN-1:0] res_t[2] = '{32'h80000000, 32'h1};
    for (int i = 0; i < 2; i++) begin
      int cyc;
      logic [EW-1:0] e;
      drive_op(rs1_t[i], rs2_t[i], 32'h0, 1'b0, op_t[i], 1'b0);
      wait_valid(cyc);
      e = exp_q.pop_front();
      checks++;
      if (!bus.out_valid || act !== e || bus.out_result !== res_t[i]) begin
        errors++;
        $display("FAIL ovf_slt[%0d]: valid=%0b got %h, required %h", i, bus.out_valid, act, e);
      end
      release_result();
    end
  endtask

  task automatic test_branch_hold();
    int cyc;
    int bad = 0;
    logic [EW-1:0] e;
    drive_op(32'h1234, 32'h1234, 32'h0, 1'b0, 4'd1, 1'b1);
    wait_valid(cyc);
    e = exp_q.pop_front();
    checks++;
    if (!bus.out_valid || act !== e || bus.out_zero !== 1'b1) begin
      errors++;
      $display("FAIL branch_eq: valid=%0b got %h, required %h", bus.out_valid, act, e);
    end
    repeat (5) begin
      @(posedge clock);
      #1;
      if (!bus.out_valid || act !== e || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
    end
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%0b in_ready=%0b, required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush();
    int cyc;
    int seen = 0;
    logic [EW-1:0] e;
    drive_op(32'h11, 32'h22, 32'h0, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: state=%0d out_valid=%0b, required IDLE/0", dbg_state, bus.out_valid);
    end
    repeat (XLEN + 5) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_valid: out_valid seen %0d cycles, required 0", seen);
    end
    drive_op(32'd2, 32'd2, 32'd0, 1'b0, 4'd0, 1'b0);
    wait_valid(cyc);
    e = exp_q.pop_front();
    checks++;
    if (!bus.out_valid || act !== e || bus.out_result !== 32'd4) begin
      errors++;
      $display("FAIL flush_then_add: valid=%0b got %h, required %h", bus.out_valid, act, e);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [EW-1:0] e;
    drive_op(32'hFFFF0000, 32'h0000FFFF, 32'h0, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_back());
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || act !== '0 || {fa_a, fa_b, fa_cin} !== 3'b000 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b fields=%h fa=%b state=%0d, required all 0/IDLE",
               bus.out_valid, act, {fa_a, fa_b, fa_cin}, dbg_state);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drive_op(32'd5, 32'd3, 32'd0, 1'b0, 4'd9, 1'b0);
    wait_valid(cyc);
    e = exp_q.pop_front();
    checks++;
    if (!bus.out_valid || act !== e || bus.out_unsupported !== 1'b1 || bus.out_result !== 32'd8) begin
      errors++;
      $display("FAIL unsupported_op: valid=%0b got %h, required %h", bus.out_valid, act, e);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      int cyc;
      logic [EW-1:0] e;
      logic [3:0] op;
      op = 4'(($urandom_range(0, 4) == 4) ? $urandom_range(4, 15) : $urandom_range(0, 3));
      drive_op($urandom, (i % 3 == 0) ? 32'h80000000 : $urandom, $urandom,
               1'($urandom_range(0, 1)), op, ($urandom_range(0, 3) == 0));
      wait_valid(cyc);
      e = exp_q.pop_front();
      checks++;
      if (!bus.out_valid || act !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%0b got %h, required %h", i, bus.out_valid, act, e);
      end
      release_result();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.in_valid      = 1'b0;
    bus.in_rs1        = '0;
    bus.in_rs2        = '0;
    bus.in_imm        = '0;
    bus.in_ctrlALUSrc = 1'b0;
    bus.in_ctrlOP     = 4'd0;
    bus.in_ctrlBranch = 1'b0;
    bus.out_ready     = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    test_reset();
    test_add();
    test_sub_sltu();
    test_ovf_slt();
    test_branch_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
